// File: rtl/alu_mult_sequencer_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM states and ALU op codes.
package alu_mult_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_t;

endpackage

// File: rtl/ArithmeticLogicUnit.sv
// Combinational W-bit ALU; CO is the unsigned carry-out for ADD and the no-borrow flag for SUB.
module ArithmeticLogicUnit
  import alu_mult_sequencer_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  alu_op_t      ALU_CNTRL,
  output logic [W-1:0] Result,
  output logic         CO
);

  localparam int unsigned XW = W + 1;

  logic [XW-1:0] add_c;
  logic [XW-1:0] sub_c;

  assign add_c = {1'b0, A} + {1'b0, B};
  assign sub_c = {1'b0, A} + {1'b0, ~B} + XW'(1);

  always_comb begin
    Result = '0;
    CO     = 1'b0;
    case (ALU_CNTRL)
      ALU_ADD: begin
        Result = add_c[W-1:0];
        CO     = add_c[W];
      end
      ALU_SUB: begin
        Result = sub_c[W-1:0];
        CO     = sub_c[W];
      end
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_XOR: Result = A ^ B;
      ALU_SLT: Result = W'(A < B);
      default: Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mult_sequencer.sv
// Unsigned W x W -> 2W shift-add multiplier: one ALU add per cycle for exactly W cycles,
// valid/ready request and result handshakes, result held until consumed.
module alu_mult_sequencer
  import alu_mult_sequencer_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         START_VALID,
  output logic         START_READY,
  input  logic [W-1:0] Input1,
  input  logic [W-1:0] Input2,
  output logic         RES_VALID,
  input  logic         RES_READY,
  output logic [W-1:0] DataOutHi,
  output logic [W-1:0] DataOutLo,
  output logic         Z,
  output logic         OVF
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_t       state;
  state_t       state_next;
  logic [W-1:0] m;
  logic [W-1:0] mq;
  logic [W-1:0] acc;
  logic [CW-1:0] cnt;

  logic [W-1:0] addend_c;
  logic [W-1:0] sum_c;
  logic         co_c;
  logic         accept_c;
  logic         last_c;

  assign accept_c = START_VALID && (state == ST_IDLE);
  assign last_c   = (cnt == CW'(W - 1));
  assign addend_c = mq[0] ? m : '0;

  ArithmeticLogicUnit #(.W(W)) u_alu (
    .A         (acc),
    .B         (addend_c),
    .ALU_CNTRL (ALU_ADD),
    .Result    (sum_c),
    .CO        (co_c)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (START_VALID)  state_next = ST_RUN;
      ST_RUN:  if (last_c)       state_next = ST_DONE;
      ST_DONE: if (RES_READY)    state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Datapath: {ACC,MQ} shifts right one bit per RUN cycle, carry enters ACC MSB
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m   <= '0;
      mq  <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      if (accept_c) begin
        m   <= Input1;
        mq  <= Input2;
        acc <= '0;
        cnt <= '0;
      end else if (state == ST_RUN) begin
        acc <= {co_c, sum_c[W-1:1]};
        mq  <= {sum_c[0], mq[W-1:1]};
        cnt <= last_c ? '0 : cnt + CW'(1);
      end
    end
  end

  assign START_READY = (state == ST_IDLE);
  assign RES_VALID   = (state == ST_DONE);
  assign DataOutHi   = acc;
  assign DataOutLo   = mq;
  assign Z           = ~|{acc, mq};
  assign OVF         = |acc;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed and randomized checks of alu_mult_sequencer against a plain-multiply reference.
module tb_alu_mult_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 2 * W;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         START_VALID;
  logic         START_READY;
  logic [W-1:0] Input1;
  logic [W-1:0] Input2;
  logic         RES_VALID;
  logic         RES_READY;
  logic [W-1:0] DataOutHi;
  logic [W-1:0] DataOutLo;
  logic         Z;
  logic         OVF;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  alu_mult_sequencer #(.W(W)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .START_VALID (START_VALID),
    .START_READY (START_READY),
    .Input1      (Input1),
    .Input2      (Input2),
    .RES_VALID   (RES_VALID),
    .RES_READY   (RES_READY),
    .DataOutHi   (DataOutHi),
    .DataOutLo   (DataOutLo),
    .Z           (Z),
    .OVF         (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  // Called one edge after the accepting edge; waits for the result, stalls, then consumes it.
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    logic [PW-1:0] p;
    int cycles;
    p = ref_prod(a, b);
    check("busy_after_accept", PW'(START_READY), PW'(0));
    cycles = 0;
    while (RES_VALID !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    check("latency", PW'(cycles), PW'(W));
    check("product", {DataOutHi, DataOutLo}, p);
    check("flags_z_ovf", PW'({Z, OVF}), PW'({p == '0, p[PW-1:W] != '0}));
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_hold", {DataOutHi, DataOutLo}, p);
      check("stall_hs", PW'({START_READY, RES_VALID}), PW'(2'b01));
    end
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    check("post_handshake", PW'({START_READY, RES_VALID}), PW'(2'b10));
    check("idle_retain", {DataOutHi, DataOutLo}, p);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    Input1      = a;
    Input2      = b;
    START_VALID = 1'b1;
    tick();
    START_VALID = 1'b0;
    Input1      = W'($urandom);
    Input2      = W'($urandom);
    finish_op(a, b, stall);
  endtask

  initial begin
    logic [PW-1:0] p;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            cycles;

    RESET_N     = 1'b0;
    START_VALID = 1'b0;
    RES_READY   = 1'b0;
    Input1      = '0;
    Input2      = '0;
    #12;
    check("reset_hs", PW'({START_READY, RES_VALID}), PW'(2'b10));
    check("reset_data", {DataOutHi, DataOutLo}, '0);
    check("reset_flags", PW'({Z, OVF}), PW'(2'b10));
    RESET_N = 1'b1;
    tick();
    check("idle_no_req", PW'({START_READY, RES_VALID}), PW'(2'b10));

    do_op(W'(3), W'(5), 0);
    do_op('1, '1, 1);
    do_op(W'(32'h1234_5678), '0, 2);
    do_op('0, W'(32'hDEAD_BEEF), 0);
    do_op(W'(1), '1, 0);

    // Result held under back-pressure while new requests are ignored
    a = W'(32'h0000_ABCD);
    b = W'(32'h0000_1234);
    p = ref_prod(a, b);
    Input1      = a;
    Input2      = b;
    START_VALID = 1'b1;
    tick();
    START_VALID = 1'b0;
    cycles = 0;
    while (RES_VALID !== 1'b1 && cycles < 200) begin
      START_VALID = cycles[0];
      Input1      = W'($urandom);
      tick();
      cycles++;
    end
    START_VALID = 1'b0;
    check("bp_latency", PW'(cycles), PW'(W));
    for (int i = 0; i < 10; i++) begin
      START_VALID = (i % 2 == 0);
      Input1      = W'($urandom);
      Input2      = W'($urandom);
      tick();
      check("bp_data", {DataOutHi, DataOutLo}, p);
      check("bp_hs", PW'({START_READY, RES_VALID}), PW'(2'b01));
    end
    Input1      = W'(6);
    Input2      = W'(7);
    START_VALID = 1'b1;
    RES_READY   = 1'b1;
    tick();
    RES_READY = 1'b0;
    check("bp_release_idle", PW'({START_READY, RES_VALID}), PW'(2'b10));
    tick();
    START_VALID = 1'b0;
    finish_op(W'(6), W'(7), 0);

    // Reset in the middle of RUN discards the operation immediately
    Input1      = W'(32'h0F0F_0F0F);
    Input2      = W'(32'h7777_7777);
    START_VALID = 1'b1;
    tick();
    START_VALID = 1'b0;
    repeat (10) tick();
    check("pre_reset_run", PW'({START_READY, RES_VALID}), PW'(2'b00));
    #2;
    RESET_N = 1'b0;
    #1;
    check("midrun_reset_hs", PW'({START_READY, RES_VALID}), PW'(2'b10));
    check("midrun_reset_data", {DataOutHi, DataOutLo}, '0);
    check("midrun_reset_z", PW'({Z, OVF}), PW'(2'b10));
    #1;
    RESET_N = 1'b1;
    do_op(W'(7), W'(9), 1);

    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0:       a = '0;
        1:       a = '1;
        2:       a = W'($urandom_range(0, 15));
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = '1;
        2:       b = W'($urandom_range(0, 15));
        default: b = W'($urandom);
      endcase
      do_op(a, b, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_mult_sequencer.md
ALU_MULT_SEQUENCER -- requirements
Module: alu_mult_sequencer

Interface
REQ-001 The block SHALL take parameter W, default 32, giving the operand width in bits (W >= 2, power of two).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET_N, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port START_VALID, input, 1, requesting that a multiply start.
REQ-005 The block SHALL have port START_READY, output, 1, indicating the block is idle and can accept a request.
REQ-006 The block SHALL have ports Input1 and Input2, input, W, the unsigned multiplicand and multiplier, sampled only on accept.
REQ-007 The block SHALL have port RES_VALID, output, 1, indicating the result is held valid.
REQ-008 The block SHALL have port RES_READY, input, 1, the consumer acceptance of the result.
REQ-009 The block SHALL have ports DataOutHi and DataOutLo, output, W each, the upper and lower halves of the 2W-bit product.
REQ-010 The block SHALL have port Z, output, 1, asserted when the full 2W-bit product is zero.
REQ-011 The block SHALL have port OVF, output, 1, asserted when DataOutHi is non-zero, meaning the product does not fit in W bits.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, RUN and DONE.
REQ-013 START_READY SHALL equal (state==IDLE) combinationally, and RES_VALID SHALL equal (state==DONE).
REQ-014 An accept SHALL occur on the edge where START_VALID and START_READY are both 1; on that edge the block SHALL load M=Input1, MQ=Input2, ACC=0, CNT=0 and go IDLE->RUN.
REQ-015 In IDLE without START_VALID, the FSM SHALL stay in IDLE and all registers SHALL hold.
REQ-016 Each RUN cycle SHALL form {CO,sum} = ACC + (MQ[0] ? M : 0) through the ALU add operation (ALU_CNTRL=000), then load {ACC,MQ} <= {CO,sum,MQ} >> 1 and CNT <= CNT+1.
REQ-017 RUN SHALL last exactly W cycles for every operand value, with no early exit on zero operands.
REQ-018 The FSM SHALL go RUN->DONE on the edge where CNT==W-1; RES_VALID SHALL therefore rise W edges after the accepting edge.
REQ-019 In DONE, DataOutHi=ACC and DataOutLo=MQ; Z and OVF SHALL derive from these registers and remain stable while RES_VALID=1.
REQ-020 DONE SHALL hold until RES_VALID and RES_READY are both 1 on an edge, then go to IDLE; there is no timeout.
REQ-021 START_VALID during RUN or DONE SHALL be ignored: it is not queued and does not disturb the operation in flight.
REQ-022 A new request SHALL be accepted no earlier than the edge after the result handshake, giving a minimum issue interval of W+2 cycles.
REQ-023 CNT SHALL be $clog2(W) bits wide, wrap to 0 on leaving RUN, and never be compared beyond W-1.
REQ-024 Z, OVF, DataOutHi and DataOutLo SHALL retain the last result in IDLE; they are valid only while RES_VALID=1.

Reset
REQ-025 RESET_N=0 SHALL immediately force state=IDLE and ACC, MQ, M and CNT to 0, giving START_READY=1, RES_VALID=0, DataOutHi=DataOutLo=0, Z=1 and OVF=0.
REQ-026 A reset asserted during RUN or DONE SHALL discard the operation with no result handshake; the first edge after release SHALL behave as IDLE.

Structure
REQ-027 FSM state encodings and the ALU_CNTRL add code (000) SHALL live in a shared package, with W kept as the module parameter.
REQ-028 The block SHALL instantiate exactly one sub-module, ArithmeticLogicUnit #(W), used only for the add; all shifting and muxing SHALL stay local.

Verification
REQ-029 Input1=3, Input2=5 -> RES_VALID rises W edges after accept; Hi=0, Lo=15, Z=0, OVF=0.
REQ-030 Input1=Input2=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, OVF=1, Z=0, exercising the carry CO into ACC.
REQ-031 Input1=0x12345678, Input2=0 -> Hi=Lo=0, Z=1, OVF=0, still taking W RUN cycles.
REQ-032 Hold RES_READY=0 for 10 cycles in DONE while pulsing START_VALID -> outputs stable, START_READY=0, no new accept; after release the next accept comes 1 edge after the handshake.
REQ-033 Assert RESET_N=0 mid-RUN (CNT=10) -> START_READY=1 and RES_VALID=0 with no clock edge; after release, 7*9 yields Lo=63.
REQ-034 Run 1000 random back-to-back operands with random RES_READY stalls -> every {Hi,Lo} matches a 2W-bit reference product.
